// File: rtl/mem_port_if.sv
// Memory bus between mem_port (master) and the memory model or controller (slave).
interface mem_port_if #(
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port.sv
// Multicycle-CPU memory port: latches one access, runs it on the bus, captures IR/MDR.
// Optional bus timeout enabled with `define MEM_PORT_TIMEOUT_EN.
module mem_port #(
    parameter int DW     = 32,
    parameter int TO_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] wdata,
    input  logic          IorD,
    input  logic          IRWrite,
    input  logic          acc_req,
    input  logic          acc_we,
    mem_port_if.master    bus,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] mdr,
    output logic          stall,
    output logic          done,
    output logic          bus_err
);

    localparam logic [DW-1:0] ALIGN_MASK = {{(DW-2){1'b1}}, 2'b00};

    if (TO_CYC < 2) begin : g_to_cyc_check
        $error("mem_port: TO_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t        state_r;
    logic          mem_req_r;
    logic          mem_we_r;
    logic          irw_r;
    logic          done_r;
    logic [DW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] ir_r;
    logic [DW-1:0] mdr_r;
    logic [DW-1:0] addr_sel_s;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] wait_cnt_r;
    logic          bus_err_r;
`endif

    // Word-aligned address selection between fetch and data address
    always_comb begin
        addr_sel_s = {DW{1'b0}};
        if (IorD) begin
            addr_sel_s = alu_out & ALIGN_MASK;
        end else begin
            addr_sel_s = pc & ALIGN_MASK;
        end
    end

    // Access FSM with all bus and register outputs held in flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            irw_r      <= 1'b0;
            done_r     <= 1'b0;
            addr_r     <= {DW{1'b0}};
            wdata_r    <= {DW{1'b0}};
            ir_r       <= {DW{1'b0}};
            mdr_r      <= {DW{1'b0}};
`ifdef MEM_PORT_TIMEOUT_EN
            wait_cnt_r <= {CW{1'b0}};
            bus_err_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (acc_req) begin
                        addr_r     <= addr_sel_s;
                        wdata_r    <= wdata;
                        mem_we_r   <= acc_we;
                        irw_r      <= IRWrite;
                        mem_req_r  <= 1'b1;
`ifdef MEM_PORT_TIMEOUT_EN
                        wait_cnt_r <= {CW{1'b0}};
`endif
                        state_r    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack) begin
                        // A store wins over IRWrite; only reads update ir/mdr
                        if (!mem_we_r) begin
                            if (irw_r) begin
                                ir_r <= bus.mem_rdata;
                            end else begin
                                mdr_r <= bus.mem_rdata;
                            end
                        end
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end
`ifdef MEM_PORT_TIMEOUT_EN
                    else if (wait_cnt_r == CW'(TO_CYC - 1)) begin
                        bus_err_r <= 1'b1;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
`else
                    else begin
                        state_r <= ST_BUSY;
                    end
`endif
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign ir            = ir_r;
    assign mdr           = mdr_r;
    assign done          = done_r;
    // Combinational so the controller is held from the very cycle it raises acc_req
    assign stall         = acc_req & ~done_r;

`ifdef MEM_PORT_TIMEOUT_EN
    assign bus_err = bus_err_r;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 Parameter DW, default 32, data/address width in bits.
REQ-002 Parameter TO_CYC, default 16, wait-cycle limit before a bus error (used only when MEM_PORT_TIMEOUT_EN is defined).
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc  in  DW  instruction fetch address.
REQ-006 alu_out  in  DW  data address for load/store.
REQ-007 wdata  in  DW  store data.
REQ-008 IorD  in  1  address select: 0 selects pc, 1 selects alu_out.
REQ-009 IRWrite  in  1  access is an instruction fetch.
REQ-010 acc_req  in  1  access request, held high by the controller until done.
REQ-011 acc_we  in  1  access is a store.
REQ-012 mem_req  out  1  bus request to memory.
REQ-013 mem_we  out  1  bus write enable.
REQ-014 mem_addr  out  DW  bus address.
REQ-015 mem_wdata  out  DW  bus write data.
REQ-016 mem_ack  in  1  bus completion, one cycle per transaction.
REQ-017 mem_rdata  in  DW  bus read data, valid when mem_ack=1.
REQ-018 ir  out  DW  instruction register.
REQ-019 mdr  out  DW  memory data register.
REQ-020 stall  out  1  controller hold: equals acc_req & ~done.
REQ-021 done  out  1  single-cycle completion pulse.
REQ-022 bus_err  out  1  sticky timeout flag.

Function
REQ-023 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-024 In IDLE with acc_req=1, the block SHALL latch the address, wdata, acc_we and IRWrite, then move to BUSY.
- Latched address: IorD ? alu_out : pc, with bits [1:0] forced to 00.
REQ-025 In BUSY, mem_req SHALL be 1, with mem_addr, mem_we and mem_wdata driven from the latched values and held stable until ack.
REQ-026 In BUSY with mem_ack=1, the block SHALL go to DONE and deassert mem_req in the next cycle.
- Read with latched IRWrite=1: capture mem_rdata into ir.
- Read with latched IRWrite=0: capture mem_rdata into mdr.
- Write: capture nothing.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
- A still-high acc_req starts a new access from IDLE on the following edge.
REQ-028 Minimum latency SHALL be 2 cycles, acc_req rise to done, when mem_ack arrives in the first BUSY cycle.
REQ-029 When the latched acc_we and IRWrite are both 1, the access SHALL be a write and ir SHALL be left unchanged.
REQ-030 mem_ack SHALL be ignored in IDLE and DONE.
REQ-031 If acc_req drops during BUSY, the transaction SHALL still complete and done SHALL still pulse.
REQ-032 ir and mdr SHALL hold their values in every cycle other than a capturing ack.

Reset
REQ-033 While rst=1, the block SHALL drive the following values immediately (asynchronously):
- state IDLE;
- mem_req=0, mem_we=0, done=0, bus_err=0;
- mem_addr=0, mem_wdata=0, ir=0, mdr=0.
REQ-034 A reset during BUSY SHALL abort the transaction, and a mem_ack arriving after reset release SHALL be ignored.

Configuration
REQ-035 With MEM_PORT_TIMEOUT_EN defined, a wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-036 With MEM_PORT_TIMEOUT_EN defined, reaching TO_CYC-1 without ack SHALL set bus_err and move the FSM to DONE.
- bus_err stays set until reset.
- mem_req drops in the next cycle.
- ir and mdr are not updated.
- done pulses normally.
REQ-037 Without MEM_PORT_TIMEOUT_EN, bus_err SHALL be constant 0 and BUSY SHALL wait indefinitely for mem_ack.

Verification
REQ-038 Fetch: pc=0x00003004, IorD=0, IRWrite=1, acc_req=1, mem_ack in the first BUSY cycle with rdata=0x8C430004 -> mem_addr=0x00003004, ir=0x8C430004, done at cycle 2, stall high for cycles 0-1.
REQ-039 Load with 3 wait cycles: alu_out=0x00000013, IorD=1 -> mem_addr=0x00000010, mdr=rdata, ir unchanged, done 5 cycles after acc_req.
REQ-040 Store: alu_out=0x20, wdata=0xDEADBEEF, acc_we=1 -> mem_we=1 and mem_wdata=0xDEADBEEF for the whole of BUSY, mdr and ir unchanged.
REQ-041 Reset asserted during BUSY, then mem_ack pulsed after release -> mem_req=0 immediately, FSM in IDLE, no done, ir and mdr=0.
REQ-042 Timeout (macro on, TO_CYC=16), no ack -> bus_err=1 after 16 BUSY cycles, done pulses once, bus_err stays 1 through later accesses; macro off -> mem_req stays 1 and bus_err=0.
